// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sampling slice.
// Contents:
//   state_e               - burst-writer FSM state {IDLE, BURST}
//   DEF_*                 - default parameter values for the sampler
//   ch_base()             - elaboration-time helper for per-channel ring-buffer bases
package adc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int DEF_NUM_CH          = 2;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_ADDR_W          = 12;
    localparam int DEF_DEPTH           = 640;
    localparam int DEF_BASE_ADDR       = 32'h0000_0100;
    localparam int DEF_SAMPLE_INTERVAL = 175000;   // 5 ms at 35 MHz

    // Word address of slot 0 of channel ch. Only ever evaluated on constants,
    // so it folds into a lookup table rather than a multiplier.
    function automatic int ch_base(input int base, input int ch, input int depth);
        return base + ch * depth;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Periodic tick generator shared by periodic blocks.
// Ports:
//   enable  in   count while high; low clears and holds the counter
//   clock   in   system clock
//   reset   in   asynchronous, active-high
//   tick    out  high for one cycle when the counter sits at INTERVAL-1
module sample_tick_gen #(
    parameter int INTERVAL = adc_pkg::DEF_SAMPLE_INTERVAL,
    localparam int CNT_W   = $clog2(INTERVAL)
) (
    input  logic enable,
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(INTERVAL - 2);

    logic [CNT_W-1:0] count_r;
    logic             tick_r;

    // Interval counter; tick is registered one step early so it coincides
    // with count_r == INTERVAL-1 without a combinational decode on the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else if (enable) begin
            count_r <= (count_r == CNT_LAST) ? '0 : count_r + CNT_W'(1'b1);
            tick_r  <= (count_r == CNT_PRE);
        end else begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodic multi-channel ADC sampler. On each tick all NUM_CH channel words are
// snapshotted together, then written as a NUM_CH-cycle burst into per-channel
// ring buffers over RAM port B. Outside a burst, port B belongs to the VGA reader.
// Ports:
//   clock, reset   system clock; asynchronous active-high reset
//   enable         sampling enable
//   ch_data        channel c at [c*DATA_W +: DATA_W]
//   vga_addr       VGA read address (passed to port B when idle)
//   ram_we/addr/wdata  RAM port B write interface
//   vga_rdata_ok   port B read data this cycle answers last cycle's vga_addr
//   wr_ptr         slot of the most recently completed sample set
//   buf_wrap       one-cycle pulse when slot DEPTH-1 completes
//   busy           burst in progress
//   overrun        sticky: tick arrived while a burst was running
module adc_sample_scheduler
    import adc_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int BASE_ADDR       = DEF_BASE_ADDR,
    parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
    localparam int PTR_W          = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [ADDR_W-1:0]        vga_addr,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     vga_rdata_ok,
    output logic [PTR_W-1:0]         wr_ptr,
    output logic                     buf_wrap,
    output logic                     busy,
    output logic                     overrun
);

    localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [PTR_W-1:0] SLOT_LAST = PTR_W'(DEPTH - 1);

    if (SAMPLE_INTERVAL <= NUM_CH) begin : g_bad_interval
        $error("adc_sample_scheduler: SAMPLE_INTERVAL must exceed NUM_CH");
    end
    if (BASE_ADDR + NUM_CH * DEPTH > (1 << ADDR_W)) begin : g_bad_range
        $error("adc_sample_scheduler: ring buffers exceed port B address space");
    end

    state_e            state_r;
    logic [CH_W-1:0]   ch_idx_r;
    logic [PTR_W-1:0]  slot_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic              buf_wrap_r;
    logic              overrun_r;
    logic              vga_rdata_ok_r;
    logic [DATA_W-1:0] snap_r [NUM_CH];
    logic              tick_s;
    logic [ADDR_W-1:0] ch_base_s [NUM_CH];

    sample_tick_gen #(
        .INTERVAL (SAMPLE_INTERVAL)
    ) u_tick_gen (
        .enable (enable),
        .clock  (clock),
        .reset  (reset),
        .tick   (tick_s)
    );

    // Constant per-channel base addresses, so the burst address is a table lookup plus slot.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_base
        assign ch_base_s[c] = ADDR_W'(ch_base(BASE_ADDR, c, DEPTH));
    end

    // Burst FSM with snapshot, slot bookkeeping and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            ch_idx_r       <= '0;
            slot_r         <= '0;
            wr_ptr_r       <= '0;
            buf_wrap_r     <= 1'b0;
            overrun_r      <= 1'b0;
            vga_rdata_ok_r <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                snap_r[c] <= '0;
            end
        end else begin
            // RAM read has one cycle of latency, so read data is valid for the
            // VGA only if port B was idle on the previous cycle.
            vga_rdata_ok_r <= (state_r == IDLE);
            buf_wrap_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        state_r  <= BURST;
                        ch_idx_r <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            snap_r[c] <= ch_data[c*DATA_W +: DATA_W];
                        end
                    end
                end
                BURST: begin
                    if (tick_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (ch_idx_r == CH_LAST) begin
                        state_r    <= IDLE;
                        ch_idx_r   <= '0;
                        wr_ptr_r   <= slot_r;
                        slot_r     <= (slot_r == SLOT_LAST) ? '0 : slot_r + PTR_W'(1'b1);
                        buf_wrap_r <= (slot_r == SLOT_LAST);
                    end else begin
                        ch_idx_r <= ch_idx_r + CH_W'(1'b1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ch_idx_r <= '0;
                end
            endcase
        end
    end

    // Port B ownership: writer during a burst, VGA reader otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = vga_addr;
        ram_wdata = '0;
        case (state_r)
            BURST: begin
                ram_we    = 1'b1;
                ram_addr  = ch_base_s[ch_idx_r] + ADDR_W'(slot_r);
                ram_wdata = snap_r[ch_idx_r];
            end
            IDLE: begin
                ram_we    = 1'b0;
                ram_addr  = vga_addr;
                ram_wdata = '0;
            end
            default: begin
                ram_we    = 1'b0;
                ram_addr  = vga_addr;
                ram_wdata = '0;
            end
        endcase
    end

    assign vga_rdata_ok = vga_rdata_ok_r;
    assign wr_ptr       = wr_ptr_r;
    assign buf_wrap     = buf_wrap_r;
    assign busy         = (state_r == BURST);
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed testbench for adc_sample_scheduler (3 channels, depth 4, interval 8).
// Cycle numbering: rel = 0 is the first cycle after reset is released; the
// tick lands on rel 7 and the first burst write on rel 8.
module tb_adc_sample_scheduler;

    localparam int NUM_CH   = 3;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 4;
    localparam int BASE     = 32'h100;
    localparam int INTERVAL = 8;
    localparam int PTR_W    = 2;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [ADDR_W-1:0]        vga_addr;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic                     vga_rdata_ok;
    logic [PTR_W-1:0]         wr_ptr;
    logic                     buf_wrap;
    logic                     busy;
    logic                     overrun;

    int n_checks = 0;
    int n_errors = 0;
    int rel      = 0;

    always #5 clock = ~clock;

    adc_sample_scheduler #(
        .NUM_CH          (NUM_CH),
        .DATA_W          (DATA_W),
        .ADDR_W          (ADDR_W),
        .DEPTH           (DEPTH),
        .BASE_ADDR       (BASE),
        .SAMPLE_INTERVAL (INTERVAL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .ch_data      (ch_data),
        .vga_addr     (vga_addr),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .vga_rdata_ok (vga_rdata_ok),
        .wr_ptr       (wr_ptr),
        .buf_wrap     (buf_wrap),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n cycles; sample/drive 1 ns after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
        rel += n;
    endtask

    task automatic goto(input int target);
        if (target > rel) begin
            step(target - rel);
        end
    endtask

    // Checks a full burst starting at rel `start` into `slot`, then the idle cycle after it.
    task automatic check_burst(input int start, input int slot,
                               input int d0, input int d1, input int d2);
        int d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        goto(start);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check_eq($sformatf("we r%0d", rel), ram_we, 1);
            check_eq($sformatf("busy r%0d", rel), busy, 1);
            check_eq($sformatf("addr r%0d", rel), ram_addr, BASE + ch * DEPTH + slot);
            check_eq($sformatf("wdata r%0d", rel), ram_wdata, d[ch]);
            step(1);
        end
        check_eq($sformatf("we_end r%0d", rel), ram_we, 0);
        check_eq($sformatf("busy_end r%0d", rel), busy, 0);
        check_eq($sformatf("wr_ptr r%0d", rel), wr_ptr, slot);
        check_eq($sformatf("buf_wrap r%0d", rel), buf_wrap, (slot == DEPTH - 1) ? 1 : 0);
    endtask

    initial begin
        int idle_we;
        int waited;

        reset    = 1'b1;
        enable   = 1'b0;
        ch_data  = '0;
        vga_addr = 12'h050;
        step(3);

        // Reset state
        check_eq("rst ram_we", ram_we, 0);
        check_eq("rst ram_addr", ram_addr, 12'h050);
        check_eq("rst ram_wdata", ram_wdata, 0);
        check_eq("rst wr_ptr", wr_ptr, 0);
        check_eq("rst buf_wrap", buf_wrap, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst overrun", overrun, 0);
        check_eq("rst vga_ok", vga_rdata_ok, 0);

        reset   = 1'b0;
        enable  = 1'b1;
        ch_data = {32'd3, 32'd2, 32'd1};
        rel     = 0;

        step(1);
        check_eq("vga_ok idle", vga_rdata_ok, 1);
        goto(7);
        check_eq("no write before tick", ram_we, 0);

        // First burst with VGA-ok lag
        goto(8);
        check_eq("vga_ok burst c0", vga_rdata_ok, 1);
        step(1);
        check_eq("vga_ok burst c1", vga_rdata_ok, 0);
        check_eq("vga addr hidden", ram_addr, 12'h104);
        step(1);
        check_eq("vga_ok burst c2", vga_rdata_ok, 0);
        step(1);
        check_eq("vga_ok lag", vga_rdata_ok, 0);
        check_eq("vga addr back", ram_addr, 12'h050);
        step(1);
        check_eq("vga_ok restored", vga_rdata_ok, 1);

        // Re-check the first burst contents via a fresh reset would cost time;
        // the next bursts cover data/address/wr_ptr sequencing.
        goto(16);
        ch_data = {32'hC, 32'hB, 32'hA};       // changed one cycle after tick
        check_burst(16, 1, 1, 2, 3);            // still the snapshot from the tick edge
        check_burst(24, 2, 'hA, 'hB, 'hC);
        check_burst(32, 3, 'hA, 'hB, 'hC);      // buf_wrap pulses at rel 35
        step(1);
        check_eq("buf_wrap one cycle", buf_wrap, 0);
        check_burst(40, 0, 'hA, 'hB, 'hC);      // wraps back to slot 0

        vga_addr = 12'h0AB;
        #1;
        check_eq("vga addr follow", ram_addr, 12'h0AB);

        // enable low mid-interval for 20 cycles
        goto(44);
        enable  = 1'b0;
        idle_we = 0;
        for (int i = 0; i < 20; i++) begin
            if (ram_we || busy) idle_we++;
            step(1);
        end
        check_eq("no write disabled", idle_we, 0);
        enable = 1'b1;
        waited = 0;
        while (!ram_we && waited < 30) begin
            step(1);
            waited++;
        end
        check_eq("reenable latency", waited, 8);
        check_burst(72, 1, 'hA, 'hB, 'hC);

        // Reset during the second cycle of the next burst
        goto(80);
        check_eq("pre-reset we", ram_we, 1);
        check_eq("pre-reset addr", ram_addr, 12'h102);
        step(1);
        reset = 1'b1;
        #1;
        check_eq("abort we", ram_we, 0);
        check_eq("abort busy", busy, 0);
        check_eq("abort wr_ptr", wr_ptr, 0);
        check_eq("abort addr", ram_addr, 12'h0AB);
        step(1);
        check_eq("abort we next", ram_we, 0);
        reset = 1'b0;
        rel   = 0;
        check_burst(8, 0, 'hA, 'hB, 'hC);       // slot restarted at 0

        check_eq("overrun never", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
